// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on accept, then 16 round rotations of C/D emitting
// PC-2 subkeys over valid/ready in encrypt (K1..K16) or decrypt (K16..K1) order.

// PC-1: drops parity bits, splits key into C0 (MSBs) and D0. DES bit n maps to key_i[64-n].
module des_pc1 (
  input  logic [63:0] key_i,
  output logic [55:0] cd_o
);
  logic unused_parity;

  assign cd_o = {key_i[7],  key_i[15], key_i[23], key_i[31], key_i[39], key_i[47], key_i[55],
                 key_i[63], key_i[6],  key_i[14], key_i[22], key_i[30], key_i[38], key_i[46],
                 key_i[54], key_i[62], key_i[5],  key_i[13], key_i[21], key_i[29], key_i[37],
                 key_i[45], key_i[53], key_i[61], key_i[4],  key_i[12], key_i[20], key_i[28],
                 key_i[1],  key_i[9],  key_i[17], key_i[25], key_i[33], key_i[41], key_i[49],
                 key_i[57], key_i[2],  key_i[10], key_i[18], key_i[26], key_i[34], key_i[42],
                 key_i[50], key_i[58], key_i[3],  key_i[11], key_i[19], key_i[27], key_i[35],
                 key_i[43], key_i[51], key_i[59], key_i[36], key_i[44], key_i[52], key_i[60]};

  assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                           key_i[24], key_i[16], key_i[8],  key_i[0]};
endmodule

// PC-2: selects 48 of the 56 C/D bits. CD bit n maps to cd_i[56-n].
module des_pc2 (
  input  logic [55:0] cd_i,
  output logic [47:0] sk_o
);
  logic unused_dropped;

  assign sk_o = {cd_i[42], cd_i[39], cd_i[45], cd_i[32], cd_i[55], cd_i[51], cd_i[53], cd_i[28],
                 cd_i[41], cd_i[50], cd_i[35], cd_i[46], cd_i[33], cd_i[37], cd_i[44], cd_i[52],
                 cd_i[30], cd_i[48], cd_i[40], cd_i[49], cd_i[29], cd_i[36], cd_i[43], cd_i[54],
                 cd_i[15], cd_i[4],  cd_i[25], cd_i[19], cd_i[9],  cd_i[1],  cd_i[26], cd_i[16],
                 cd_i[5],  cd_i[11], cd_i[23], cd_i[8],  cd_i[12], cd_i[7],  cd_i[17], cd_i[0],
                 cd_i[22], cd_i[3],  cd_i[10], cd_i[14], cd_i[6],  cd_i[20], cd_i[27], cd_i[24]};

  assign unused_dropped = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                            cd_i[21], cd_i[18], cd_i[13], cd_i[2]};
endmodule

module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        done
);
  localparam int unsigned HALF_W = 28;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned IDX_W  = 5;
  localparam logic [RND_W-1:0] LAST_ROUND = 4'd15;

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
  logic [RND_W-1:0]    round_q, round_d;
  logic                dir_q, dir_d;
  logic                done_q, done_d;
  logic [CD_W-1:0]     pc1_cd;
  logic [HALF_W-1:0]   c0, d0;
  logic [IDX_W-1:0]    shift_idx;
  logic                two;

  // 1-based shift table: single-bit rotations at rounds 1, 2, 9, 16.
  function automatic logic shift_is_two(input logic [IDX_W-1:0] s);
    return !(s == 5'd1 || s == 5'd2 || s == 5'd9 || s == 5'd16);
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic by2);
    return by2 ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic by2);
    return by2 ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  des_pc1 u_pc1 (.key_i(key), .cd_o(pc1_cd));
  des_pc2 u_pc2 (.cd_i({c_q, d_q}), .sk_o(subkey));

  assign {c0, d0} = pc1_cd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Next state: load from PC-1 on accept, rotate toward the next emitted subkey on each handshake.
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    round_d   = round_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    shift_idx = dir_q ? (5'd16 - IDX_W'(round_q)) : (IDX_W'(round_q) + 5'd2);
    two       = shift_is_two(shift_idx);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          c_d     = decrypt ? c0 : rotl(c0, 1'b0);
          d_d     = decrypt ? d0 : rotl(d0, 1'b0);
          round_d = '0;
          dir_d   = decrypt;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (subkey_ready) begin
          if (round_q != LAST_ROUND) begin
            round_d = round_q + 4'd1;
            c_d     = dir_q ? rotr(c_q, two) : rotl(c_q, two);
            d_d     = dir_q ? rotr(d_q, two) : rotl(d_q, two);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q == ST_EMIT);
  assign subkey_valid = (state_q == ST_EMIT);
  assign round        = round_q;
  assign done         = done_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 0x133457799BBCDFF1 key vectors.
`timescale 1ns/1ps
module tb_des_key_schedule;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        busy, subkey_valid, done;
  logic        subkey_ready = 1'b1;
  logic [47:0] subkey;
  logic [3:0]  round;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  int total = 0;
  int bad = 0;

  logic [47:0] enc_k [16];
  logic [47:0] got_sk [16];
  logic [3:0]  got_rnd [16];
  int nh, n_valid, n_done, stab_err, stab_cmp, bsy_err;
  logic finished, first_valid, done_after;
  logic [3:0]  first_round;
  logic [27:0] c_after, d_after;

  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .decrypt(decrypt),
    .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .round(round), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one schedule and records observations; all comparisons are in the calling tests.
  task automatic run_sched(input logic [63:0] k, input logic dec, input int stall_at,
                           input int stall_n, input int poke_at);
    int cyc, stalled;
    logic [47:0] hold_sk;
    logic [3:0]  hold_rnd;
    nh = 0; n_valid = 0; n_done = 0; stab_err = 0; stab_cmp = 0; bsy_err = 0;
    finished = 1'b0;
    for (int i = 0; i < 16; i++) begin got_sk[i] = 'x; got_rnd[i] = 'x; end
    key = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key = ~k; decrypt = ~dec;
    first_valid = subkey_valid; first_round = round;
    c_after = dut.c_q; d_after = dut.d_q;
    cyc = 0; stalled = 0; hold_sk = '0; hold_rnd = '0;
    while (!finished && cyc < 200) begin
      start = 1'b0;
      if (done) begin
        n_done++; finished = 1'b1;
      end else if (subkey_valid) begin
        n_valid++;
        if (!busy) bsy_err++;
        if (stall_at >= 0 && int'(round) == stall_at && stalled > 0) begin
          stab_cmp++;
          if (subkey !== hold_sk || round !== hold_rnd) stab_err++;
        end
        if (int'(round) == stall_at && stalled < stall_n) begin
          if (stalled == 0) begin hold_sk = subkey; hold_rnd = round; end
          stalled++;
          subkey_ready = 1'b0;
        end else begin
          subkey_ready = 1'b1;
          if (nh < 16) begin got_sk[nh] = subkey; got_rnd[nh] = round; end
          nh++;
        end
        if (int'(round) == poke_at) begin start = 1'b1; key = 64'h0123456789ABCDEF; end
      end
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0; subkey_ready = 1'b1;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (subkey_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", subkey_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (round !== 4'd0) begin bad++; $display("FAIL reset_round: got %0d want 0", round); end
    total++; if (subkey !== 48'h0) begin bad++; $display("FAIL reset_subkey: got %h want 0", subkey); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_encrypt();
    run_sched(KEY, 1'b0, -1, 0, -1);
    total++; if (first_valid !== 1'b1 || first_round !== 4'd0) begin bad++;
      $display("FAIL enc_latency: got valid=%b round=%0d want valid=1 round=0", first_valid, first_round); end
    total++; if (c_after !== 28'hE19955F || d_after !== 28'hAACCF1E) begin bad++;
      $display("FAIL enc_c1d1: got %h/%h want e19955f/aaccf1e", c_after, d_after); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_sk[i] !== enc_k[i] || got_rnd[i] !== 4'(i)) begin bad++;
        $display("FAIL enc_k[%0d]: got %h r%0d want %h r%0d", i, got_sk[i], got_rnd[i], enc_k[i], i); end
    end
    total++; if (n_valid !== 16 || n_done !== 1 || !finished) begin bad++;
      $display("FAIL enc_counts: got valid=%0d done=%0d want 16/1", n_valid, n_done); end
    total++; if (done_after !== 1'b0 || bsy_err !== 0) begin bad++;
      $display("FAIL enc_pulse: got done_after=%b busy_err=%0d want 0/0", done_after, bsy_err); end
  endtask

  task automatic test_decrypt();
    run_sched(KEY, 1'b1, -1, 0, -1);
    total++; if (c_after !== 28'hF0CCAAF || d_after !== 28'h556678F) begin bad++;
      $display("FAIL dec_c0d0: got %h/%h want f0ccaaf/556678f", c_after, d_after); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_sk[i] !== enc_k[15-i] || got_rnd[i] !== 4'(i)) begin bad++;
        $display("FAIL dec_k[%0d]: got %h r%0d want %h r%0d", i, got_sk[i], got_rnd[i], enc_k[15-i], i); end
    end
    total++; if (n_valid !== 16 || n_done !== 1 || done_after !== 1'b0) begin bad++;
      $display("FAIL dec_counts: got valid=%0d done=%0d want 16/1", n_valid, n_done); end
  endtask

  task automatic test_backpressure();
    run_sched(KEY, 1'b0, 4, 3, -1);
    total++; if (stab_cmp !== 3 || stab_err !== 0) begin bad++;
      $display("FAIL bp_stable: got cmp=%0d err=%0d want 3/0", stab_cmp, stab_err); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_sk[i] !== enc_k[i] || got_rnd[i] !== 4'(i)) begin bad++;
        $display("FAIL bp_k[%0d]: got %h r%0d want %h r%0d", i, got_sk[i], got_rnd[i], enc_k[i], i); end
    end
    total++; if (n_valid !== 19 || n_done !== 1) begin bad++;
      $display("FAIL bp_counts: got valid=%0d done=%0d want 19/1", n_valid, n_done); end
  endtask

  task automatic test_ignored_start();
    run_sched(KEY, 1'b0, -1, 0, 7);
    for (int i = 0; i < 16; i++) begin
      total++; if (got_sk[i] !== enc_k[i] || got_rnd[i] !== 4'(i)) begin bad++;
        $display("FAIL ign_k[%0d]: got %h r%0d want %h r%0d", i, got_sk[i], got_rnd[i], enc_k[i], i); end
    end
    total++; if (n_valid !== 16 || n_done !== 1) begin bad++;
      $display("FAIL ign_counts: got valid=%0d done=%0d want 16/1", n_valid, n_done); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    key = KEY; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!(subkey_valid && round == 4'd15) && cyc < 50) begin @(posedge clk); #1; cyc++; end
    total++; if (round !== 4'd15 || subkey !== enc_k[15]) begin bad++;
      $display("FAIL b2b_last: got r%0d %h want r15 %h", round, subkey, enc_k[15]); end
    start = 1'b1; decrypt = 1'b1;
    @(posedge clk); #1;
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL b2b_done: got done=%b busy=%b want 1/0", done, busy); end
    @(posedge clk); #1; start = 1'b0;
    total++; if (subkey_valid !== 1'b1 || round !== 4'd0 || subkey !== enc_k[15]) begin bad++;
      $display("FAIL b2b_restart: got v=%b r%0d %h want v=1 r0 %h", subkey_valid, round, subkey, enc_k[15]); end
    cyc = 0;
    while (!done && cyc < 50) begin @(posedge clk); #1; cyc++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_drain: got done=%b want 1", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic seen_done;
    key = KEY; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (subkey_valid && round != 4'd9 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    total++; if (round !== 4'd9) begin bad++; $display("FAIL rst_reach: got r%0d want r9", round); end
    #2 rst_n = 1'b0; #1;
    total++; if (busy !== 1'b0 || subkey_valid !== 1'b0 || subkey !== 48'h0) begin bad++;
      $display("FAIL rst_async: got busy=%b v=%b sk=%h want 0/0/0", busy, subkey_valid, subkey); end
    seen_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) seen_done = 1'b1; end
    rst_n = 1'b1;
    @(posedge clk); #1; if (done) seen_done = 1'b1;
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL rst_nodone: got %b want 0", seen_done); end
    run_sched(KEY, 1'b0, -1, 0, -1);
    for (int i = 0; i < 16; i++) begin
      total++; if (got_sk[i] !== enc_k[i]) begin bad++;
        $display("FAIL rst_k[%0d]: got %h want %h", i, got_sk[i], enc_k[i]); end
    end
    total++; if (n_valid !== 16 || n_done !== 1) begin bad++;
      $display("FAIL rst_counts: got valid=%0d done=%0d want 16/1", n_valid, n_done); end
  endtask

  task automatic test_corner_keys();
    logic [63:0] k;
    logic [47:0] exp;
    for (int c = 0; c < 4; c++) begin
      k   = (c < 2) ? 64'h0 : {64{1'b1}};
      exp = (c < 2) ? 48'h0 : {48{1'b1}};
      run_sched(k, 1'(c % 2), -1, 0, -1);
      for (int i = 0; i < 16; i++) begin
        total++; if (got_sk[i] !== exp || got_rnd[i] !== 4'(i)) begin bad++;
          $display("FAIL corner%0d_k[%0d]: got %h r%0d want %h r%0d", c, i, got_sk[i], got_rnd[i], exp, i); end
      end
      total++; if (n_valid !== 16 || n_done !== 1 || done_after !== 1'b0) begin bad++;
        $display("FAIL corner%0d_counts: got valid=%0d done=%0d want 16/1", c, n_valid, n_done); end
    end
  endtask

  initial begin
    enc_k = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
              48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
              48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
              48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_corner_keys();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
